// File: rtl/vga_scan_driver.sv
// VGA raster timing generator: free-running h/v scan counters, active-low syncs,
// and a pixel output stage that blanks colour outside the visible window.
module vga_scan_driver #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int PIX_LAT  = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] VGA_data,
  output logic [10:0] VGA_xpos,
  output logic [10:0] VGA_ypos,
  output logic        video_req,
  output logic        frame_start,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic [3:0]  VGA_R,
  output logic [3:0]  VGA_G,
  output logic [3:0]  VGA_B
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_ACT  = 11'(H_ACTIVE);
  localparam logic [10:0] V_ACT  = 11'(V_ACTIVE);
  localparam logic [10:0] HS_BEG = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VS_BEG = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END = 11'(V_ACTIVE + V_FP + V_SYNC);

  if (PIX_LAT < 1 || PIX_LAT > 4) begin : g_bad_lat
    $error("vga_scan_driver: PIX_LAT must be in 1..4");
  end
  if (H_TOTAL > 2047 || V_TOTAL > 2047) begin : g_bad_total
    $error("vga_scan_driver: timing totals must fit in 11 bits");
  end

  logic        run;
  logic [10:0] h_cnt;
  logic [10:0] v_cnt;
  logic        hs_raw;
  logic        vs_raw;

  logic        de_p [PIX_LAT];
  logic        hs_p [PIX_LAT+1];
  logic        vs_p [PIX_LAT+1];

  // Active-low sync while the counter sits inside the sync window.
  function automatic logic sync_level(input logic [10:0] cnt,
                                      input logic [10:0] beg_c,
                                      input logic [10:0] end_c);
    return !((cnt >= beg_c) && (cnt < end_c));
  endfunction

  // Scan counters start one edge after reset release so (0,0) is seen as a full cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run   <= 1'b0;
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      run <= 1'b1;
      if (run) begin
        if (h_cnt == H_LAST) begin
          h_cnt <= '0;
          v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 11'd1;
        end else begin
          h_cnt <= h_cnt + 11'd1;
        end
      end
    end
  end

  assign VGA_xpos    = h_cnt;
  assign VGA_ypos    = v_cnt;
  assign video_req   = run && (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign frame_start = run && (h_cnt == '0) && (v_cnt == '0);
  assign hs_raw      = sync_level(h_cnt, HS_BEG, HS_END);
  assign vs_raw      = sync_level(v_cnt, VS_BEG, VS_END);

  // p0..: display-enable follows the drawing layer's latency; syncs take one extra
  // stage to line up with the registered colour pins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PIX_LAT; i++) de_p[i] <= 1'b0;
      for (int i = 0; i <= PIX_LAT; i++) begin
        hs_p[i] <= 1'b1;
        vs_p[i] <= 1'b1;
      end
    end else begin
      de_p[0] <= video_req;
      hs_p[0] <= hs_raw;
      vs_p[0] <= vs_raw;
      for (int i = 1; i < PIX_LAT; i++) de_p[i] <= de_p[i-1];
      for (int i = 1; i <= PIX_LAT; i++) begin
        hs_p[i] <= hs_p[i-1];
        vs_p[i] <= vs_p[i-1];
      end
    end
  end

  // Pin stage: colour is forced to black whenever the delayed enable is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      VGA_R <= '0;
      VGA_G <= '0;
      VGA_B <= '0;
    end else if (de_p[PIX_LAT-1]) begin
      VGA_R <= VGA_data[11:8];
      VGA_G <= VGA_data[7:4];
      VGA_B <= VGA_data[3:0];
    end else begin
      VGA_R <= '0;
      VGA_G <= '0;
      VGA_B <= '0;
    end
  end

  assign VGA_HS = hs_p[PIX_LAT];
  assign VGA_VS = vs_p[PIX_LAT];

endmodule

// File: tb/tb_vga_scan_driver.sv
// Randomized scoreboard bench for vga_scan_driver using a reduced raster so whole
// frames, wraps and mid-frame resets fit in a short run.
module tb_vga_scan_driver;

  localparam int HA = 16, HFP = 4, HSW = 6, HBP = 4;
  localparam int VA = 8,  VFP = 2, VSW = 2, VBP = 3;
  localparam int PL = 2;
  localparam int HT = HA + HFP + HSW + HBP;
  localparam int VT = VA + VFP + VSW + VBP;
  localparam int FRAME = HT * VT;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] VGA_data;
  logic [10:0] VGA_xpos, VGA_ypos;
  logic        video_req, frame_start, VGA_HS, VGA_VS;
  logic [3:0]  VGA_R, VGA_G, VGA_B;

  vga_scan_driver #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .PIX_LAT(PL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .VGA_data(VGA_data),
    .VGA_xpos(VGA_xpos), .VGA_ypos(VGA_ypos),
    .video_req(video_req), .frame_start(frame_start),
    .VGA_HS(VGA_HS), .VGA_VS(VGA_VS),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B)
  );

  always #5 clk = ~clk;

  typedef struct { int x; int y; bit vr; bit fs; } coord_t;
  typedef struct { bit hs; bit vs; logic [11:0] rgb; } pin_t;

  coord_t      cq[$];
  pin_t        pq[$];
  logic [11:0] src_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: scan index since restart, plus run flag.
  bit run_m;
  int n_m;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic pin_t idle_pin();
    pin_t p;
    p.hs = 1'b1; p.vs = 1'b1; p.rgb = '0;
    return p;
  endfunction

  // One clock of stimulus; rst_val is the reset level applied just after the edge.
  task automatic step(input bit rst_val);
    coord_t      c;
    pin_t        p;
    logic [11:0] rnd;
    @(posedge clk);
    if (rst_n) begin
      if (run_m) n_m++;
      run_m = 1'b1;
    end else begin
      run_m = 1'b0;
      n_m   = 0;
    end
    #1;
    rst_n = rst_val;
    if (!rst_val) begin
      run_m = 1'b0;
      n_m   = 0;
      pq.delete();
      for (int i = 0; i <= PL; i++) pq.push_back(idle_pin());
    end
    c.x  = n_m % HT;
    c.y  = (n_m / HT) % VT;
    c.vr = run_m && (c.x < HA) && (c.y < VA);
    c.fs = run_m && ((n_m % FRAME) == 0);
    cq.push_back(c);
    rnd = ($urandom_range(0, 3) == 0) ? 12'hFFF : 12'($urandom);
    p.hs  = !((c.x >= HA + HFP) && (c.x < HA + HFP + HSW));
    p.vs  = !((c.y >= VA + VFP) && (c.y < VA + VFP + VSW));
    p.rgb = c.vr ? rnd : 12'h000;
    pq.push_back(p);
    src_q.push_back(rnd);
    VGA_data = src_q.pop_front();
  endtask

  // Monitor: every cycle the DUT presents a coordinate and a pin triple.
  initial begin
    coord_t c;
    pin_t   p;
    forever begin
      @(negedge clk);
      if (cq.size() != 0) begin
        c = cq.pop_front();
        check("xpos", int'(VGA_xpos), c.x);
        check("ypos", int'(VGA_ypos), c.y);
        check("video_req", int'(video_req), int'(c.vr));
        check("frame_start", int'(frame_start), int'(c.fs));
        if (pq.size() == 0) begin
          check("pin_queue_underflow", 0, 1);
        end else begin
          p = pq.pop_front();
          check("VGA_HS", int'(VGA_HS), int'(p.hs));
          check("VGA_VS", int'(VGA_VS), int'(p.vs));
          check("VGA_RGB", int'({VGA_R, VGA_G, VGA_B}), int'(p.rgb));
        end
      end
    end
  end

  initial begin
    int guard;
    rst_n    = 1'b0;
    VGA_data = '0;
    run_m    = 1'b0;
    n_m      = 0;
    for (int i = 0; i <= PL; i++) pq.push_back(idle_pin());
    for (int i = 0; i < PL; i++) src_q.push_back(12'h000);

    repeat (5) step(1'b0);
    repeat (3 * FRAME + 7) step(1'b1);

    // Mid-frame reset inside the visible area.
    guard = 0;
    while (!((n_m % HT) == HA / 2 && ((n_m / HT) % VT) == VA / 2) && guard < 2 * FRAME) begin
      step(1'b1);
      guard++;
    end
    if (guard >= 2 * FRAME) check("midframe_reach_timeout", guard, 0);
    step(1'b0);
    repeat (2) step(1'b0);
    repeat (2 * FRAME + 3) step(1'b1);

    // A few randomly placed short resets.
    for (int k = 0; k < 4; k++) begin
      repeat ($urandom_range(20, FRAME)) step(1'b1);
      repeat ($urandom_range(1, 3)) step(1'b0);
    end
    repeat (FRAME + 5) step(1'b1);

    @(negedge clk);
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_scan_driver.md
VGA_SCAN_DRIVER -- requirements
Module: vga_scan_driver

Interface
REQ-001 The module SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 The module SHALL have parameter H_FP, default 16, horizontal front porch in clocks.
REQ-003 The module SHALL have parameter H_SYNC, default 96, horizontal sync width in clocks.
REQ-004 The module SHALL have parameter H_BP, default 48, horizontal back porch in clocks.
REQ-005 The module SHALL have parameter V_ACTIVE, default 480, visible lines per frame.
REQ-006 The module SHALL have parameter V_FP, default 10, vertical front porch in lines.
REQ-007 The module SHALL have parameter V_SYNC, default 2, vertical sync width in lines.
REQ-008 The module SHALL have parameter V_BP, default 33, vertical back porch in lines.
REQ-009 The module SHALL have parameter PIX_LAT, default 1, clocks from coordinate out to VGA_data valid (range 1-4).
REQ-010 The module SHALL have port clk, input, 1, pixel clock (25 MHz for defaults); single clock domain.
REQ-011 The module SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-012 The module SHALL have port VGA_data, input, 12, RGB 4|4|4 pixel from the drawing layer, R in [11:8].
REQ-013 The module SHALL have port VGA_xpos, output, 11, current horizontal scan count.
REQ-014 The module SHALL have port VGA_ypos, output, 11, current vertical scan count.
REQ-015 The module SHALL have port video_req, output, 1, high when VGA_xpos/VGA_ypos address a visible pixel.
REQ-016 The module SHALL have port frame_start, output, 1, one-clock pulse at scan position (0,0).
REQ-017 The module SHALL have ports VGA_HS and VGA_VS, output, 1 each, active-low syncs.
REQ-018 The module SHALL have ports VGA_R, VGA_G, VGA_B, output, 4 each, pin-level colour.

Function
REQ-019 A run flag SHALL reset to 0 and SHALL set to 1 on the first clk edge after rst_n deasserts; counters SHALL hold at 0 while run=0.
REQ-020 The h counter SHALL increment each clk while run=1, 0..H_TOTAL-1 (H_TOTAL=sum of H parameters, 800 default), then wrap to 0.
REQ-021 The v counter SHALL increment only on h wrap, 0..V_TOTAL-1 (525 default), then wrap to 0 on the same edge as h wrap.
REQ-022 VGA_xpos/VGA_ypos SHALL equal h/v counters directly (registered, raw count including blanking).
REQ-023 Region order per line SHALL be active, front porch, sync, back porch; count 0 is the first visible pixel.
REQ-024 video_req SHALL = run AND h<H_ACTIVE AND v<V_ACTIVE.
REQ-025 frame_start SHALL = run AND h=0 AND v=0.
REQ-026 Raw hsync SHALL be low for H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC (656..751 default); raw vsync low for V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC (490..491), whole lines.
REQ-027 video_req SHALL be delayed PIX_LAT clocks through a shift register to form de_d, aligned with VGA_data.
REQ-028 On each clk, VGA_R/G/B SHALL register VGA_data[11:8]/[7:4]/[3:0] if de_d=1, else 0 (forced blanking, regardless of VGA_data).
REQ-029 Raw hsync/vsync SHALL be delayed PIX_LAT+1 clocks so VGA_HS/VGA_VS align with VGA_R/G/B; total coordinate-to-pin latency PIX_LAT+1.
REQ-030 All arithmetic SHALL be unsigned 11-bit; parameter sums SHALL not exceed 2047.

Reset
REQ-031 While rst_n=0 (asynchronously, including mid-frame): VGA_xpos=0, VGA_ypos=0, video_req=0, frame_start=0, VGA_HS=1, VGA_VS=1, VGA_R/G/B=0, all delay stages cleared (syncs to 1, de to 0).
REQ-032 After release, scanning SHALL restart at (0,0) with frame_start high exactly one clock after the first edge.

Verification
REQ-033 Reset: rst_n low 5 clocks -> all outputs at REQ-031 values; after release, frame_start=1 and video_req=1 for the cycle with (0,0), frame_start=0 next cycle.
REQ-034 Line timing: VGA_HS low exactly 96 clocks per line, falling edge 656+PIX_LAT+1 clocks after xpos=0, period 800 clocks.
REQ-035 Frame timing: VGA_VS low exactly 1600 clocks (lines 490-491 delayed), frame_start period 420000 clocks, xpos 799/ypos 524 followed by 0/0.
REQ-036 Latency/blanking: 1-clock registered source returning {xpos[3:0],ypos[3:0],4'hA} -> RGB at t+2 matches coords at t; RGB=0 for xpos 640..799 and ypos 480..524 even with VGA_data=12'hFFF.
REQ-037 Mid-frame reset at xpos=300, ypos=200 -> outputs to reset values without clock edge; restart per REQ-032.
